// File: rtl/ram_block_mover.sv
// ram_block_mover
// ---------------------------------------------------------------------------
// Bus-master engine that owns the data RAM port while busy=1 and copies a
// block of bytes from one RAM region to another with memmove semantics:
// when the destination lies above the source the copy runs from the top of
// the block downwards, otherwise from the bottom upwards. Overlapping
// regions are therefore copied correctly.
//
// Each byte takes two cycles: READ presents the source address and captures
// the combinational read data into a hold register. WRITE presents the
// destination address and writes the held byte.
//
// Requests are checked when they are accepted. A zero length, or a block
// that would run past DEPTH, goes straight to DONE and never touches the RAM.
//
// Optional feature (macro RAM_MOVER_FILL_EN):
//   Adds the fill_en and fill_value inputs, which are latched together with
//   start. When fill_en=1 the source is ignored, the READ state is skipped
//   and fill_value is written to every destination location.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        request strobe, sampled only in IDLE
//   src_addr     first source address
//   dst_addr     first destination address
//   length       byte count, 0..DEPTH
//   fill_en      (RAM_MOVER_FILL_EN only) fill instead of copy
//   fill_value   (RAM_MOVER_FILL_EN only) byte written in fill mode
//   busy         high in READ/WRITE
//   done         one-cycle pulse ending every accepted request
//   error        one-cycle pulse with done for a rejected request
//   mem_write    RAM write enable
//   mem_address  RAM address
//   mem_wdata    RAM write data
//   mem_rdata    RAM read data, combinational from mem_address
// ---------------------------------------------------------------------------
module ram_block_mover #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
`ifdef RAM_MOVER_FILL_EN
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE_C   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_C  = {ADDR_W{1'b0}};

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   src_ptr_r;
    logic [ADDR_W-1:0]   dst_ptr_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic [DATA_W-1:0]   hold_r;
    logic                desc_r;
    logic                err_r;

    logic                len_zero_s;
    logic                src_over_s;
    logic                dst_over_s;
    logic                range_bad_s;
    logic                fill_sel_s;
    logic                fill_mode_s;
    logic [DATA_W-1:0]   wdata_s;
    logic                dst_in_range_s;

`ifdef RAM_MOVER_FILL_EN
    logic                fill_r;
    logic [DATA_W-1:0]   fill_val_r;
`endif

    // End addresses are formed one bit wider so that src/dst + length cannot wrap.
    assign len_zero_s  = (length == ZERO_C);
    assign src_over_s  = (({1'b0, src_addr} + {1'b0, length}) > DEPTH_C);
    assign dst_over_s  = (({1'b0, dst_addr} + {1'b0, length}) > DEPTH_C);

`ifdef RAM_MOVER_FILL_EN
    // In fill mode the source address is never used, so it is not range checked.
    assign fill_sel_s  = fill_en;
    assign fill_mode_s = fill_r;
    assign wdata_s     = fill_r ? fill_val_r : hold_r;
`else
    assign fill_sel_s  = 1'b0;
    assign fill_mode_s = 1'b0;
    assign wdata_s     = hold_r;
`endif

    assign range_bad_s    = dst_over_s | (src_over_s & ~fill_sel_s);
    assign dst_in_range_s = ({1'b0, dst_ptr_r} < DEPTH_C);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start) begin
                    state_next_s = ST_IDLE;
                end else if (len_zero_s || range_bad_s) begin
                    state_next_s = ST_DONE;
                end else if (fill_sel_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_READ: begin
                state_next_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (cnt_r == ONE_C) begin
                    state_next_s = ST_DONE;
                end else if (fill_mode_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Request latch, pointer/count stepping and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ptr_r <= ZERO_C;
            dst_ptr_r <= ZERO_C;
            cnt_r     <= ZERO_C;
            hold_r    <= {DATA_W{1'b0}};
            desc_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        // A descending copy starts at the top byte of each region.
                        if ((dst_addr > src_addr) && !fill_sel_s) begin
                            desc_r    <= 1'b1;
                            src_ptr_r <= src_addr + length - ONE_C;
                            dst_ptr_r <= dst_addr + length - ONE_C;
                        end else begin
                            desc_r    <= 1'b0;
                            src_ptr_r <= src_addr;
                            dst_ptr_r <= dst_addr;
                        end
                        cnt_r <= length;
                        err_r <= ~len_zero_s & range_bad_s;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_READ: begin
                    hold_r <= mem_rdata;
                end
                ST_WRITE: begin
                    if (desc_r) begin
                        src_ptr_r <= src_ptr_r - ONE_C;
                        dst_ptr_r <= dst_ptr_r - ONE_C;
                    end else begin
                        src_ptr_r <= src_ptr_r + ONE_C;
                        dst_ptr_r <= dst_ptr_r + ONE_C;
                    end
                    cnt_r <= cnt_r - ONE_C;
                end
                ST_DONE: begin
                    cnt_r <= ZERO_C;
                end
                default: begin
                    cnt_r <= ZERO_C;
                end
            endcase
        end
    end

`ifdef RAM_MOVER_FILL_EN
    // Fill mode and fill byte are captured together with the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_r     <= 1'b0;
            fill_val_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            fill_r     <= fill_en;
            fill_val_r <= fill_value;
        end else begin
            fill_r     <= fill_r;
            fill_val_r <= fill_val_r;
        end
    end
`endif

    // Outputs are decoded only from registered state, so start never reaches the RAM port combinationally.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        mem_write   = 1'b0;
        mem_address = ZERO_C;
        mem_wdata   = {DATA_W{1'b0}};
        case (state_r)
            ST_READ: begin
                busy        = 1'b1;
                mem_address = src_ptr_r;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                mem_address = dst_ptr_r;
                mem_wdata   = wdata_s;
                // Defensive: an out-of-range destination is never written.
                mem_write   = dst_in_range_s;
            end
            ST_DONE: begin
                done  = 1'b1;
                error = err_r;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
